// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD display path.
// Holds the default widths, the saturation value shown for out-of-range
// results, the converter state type and a helper that returns the largest
// value a given number of BCD digits can represent.
package bcd_pkg;

  localparam int BIN_W_DEF  = 14;
  localparam int DIGITS_DEF = 4;
  localparam int MAX_VAL    = 9999;

  localparam logic [15:0] BCD_SAT = 16'h9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned max_val(input int digits);
    int unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/module_add3.sv
// Double-dabble nibble correction.
// Adds 3 to a BCD digit that is 5 or more, so that the following left shift
// carries correctly into the next decimal digit.
// Ports:
//   din  - scratch nibble before the shift
//   dout - corrected nibble (din + 3 when din >= 5, else din)
module module_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/module_bin_bcd.sv
// Sequential binary-to-packed-BCD converter (shift-add-3, one bit per clock).
// A start request in IDLE captures the binary value; BIN_W shift edges later
// a DONE edge publishes the result with a one-cycle listo pulse. Values above
// 10^DIGITS-1 publish all nines and raise error.
//
// Handshake: inicio is sampled only while idle (ocupado=0); the edge that
// sees inicio=1 in IDLE accepts the request and captures bin. Requests while
// ocupado=1 are dropped. listo is high for exactly one cycle, and in that
// cycle bcd/error hold the new result; they keep it until the next DONE.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   inicio  - start request
//   bin     - unsigned binary value to convert
//   bcd     - packed BCD result, bcd[3:0] is the units digit
//   listo   - one-cycle result-valid pulse
//   ocupado - conversion in progress (SHIFT or DONE)
//   error   - last accepted value was out of range
module module_bin_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inicio,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  listo,
  output logic                  ocupado,
  output logic                  error
);

  localparam int          BW   = 4 * DIGITS;
  localparam int          CW   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAXV = 32'(max_val(DIGITS));

  state_t          state;
  logic [BIN_W-1:0] shift_reg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic             err_next;

  // Per-digit add-3 correction applied before every shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    module_add3 u_add3 (
      .din  (scratch[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      err_next  <= 1'b0;
      bcd       <= '0;
      listo     <= 1'b0;
      ocupado   <= 1'b0;
      error     <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (inicio) begin
            shift_reg <= bin;
            scratch   <= '0;
            cnt       <= CW'(BIN_W);
            err_next  <= (32'(bin) > MAXV);
            ocupado   <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // The top scratch bit falls off here; any input large enough to
          // need it is already flagged by err_next and saturated.
          {scratch, shift_reg} <= {adj, shift_reg} << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd     <= err_next ? {DIGITS{4'h9}} : scratch;
          error   <= err_next;
          listo   <= 1'b1;
          ocupado <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
